// File: rtl/vm2002_coin_acceptor_if.sv
// Money-path bundle between the vend FSM and the coin acceptor.
// The master side drives coins and requests; the slave side returns credit and pulses.
interface vm2002_coin_acceptor_if #(
  parameter int CW = 16
);
  logic [1:0]    coins;
  logic          arm;
  logic          cancel;
  logic          charge_valid;
  logic [CW-1:0] charge_amt;
  logic [CW-1:0] credit;
  logic          busy;
  logic          charge_ok;
  logic          charge_nak;
  logic          refund_valid;
  logic [CW-1:0] refund;
  logic          reject;
  logic          timeout;

  modport master (
    output coins, arm, cancel,
    output charge_valid, charge_amt,
    input  credit, busy, charge_ok,
    input  charge_nak, refund_valid,
    input  refund, reject, timeout
  );

  modport slave (
    input  coins, arm, cancel,
    input  charge_valid, charge_amt,
    output credit, busy, charge_ok,
    output charge_nak, refund_valid,
    output refund, reject, timeout
  );
endinterface

// File: rtl/vm2002_coin_acceptor.sv
// Coin acceptor: edge-qualified coins, saturating credit,
// one charge per session, inactivity watchdog and refund.
module vm2002_coin_acceptor #(
  parameter int CW          = 16,
  parameter int MAX_CREDIT  = 995,
  parameter int TIMEOUT_CYC = 512
) (
  input logic                   clk,
  input logic                   hrst,
  input logic                   srst,
  vm2002_coin_acceptor_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_RELOAD = TW'(TIMEOUT_CYC - 1);
  localparam logic [CW:0] MAX_C = (CW+1)'(MAX_CREDIT);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    REFUND
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic [CW-1:0] refund_q, refund_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    coins_q;
  logic          ok_q, ok_d;
  logic          nak_q, nak_d;
  logic          rv_q, rv_d;
  logic          rej_q, rej_d;
  logic          to_q, to_d;
  logic          coin_ev;
  logic [CW-1:0] coin_val;
  logic [CW:0]   sum;

  // A code only counts on the transition out of "no coin".
  assign coin_ev = (bus.coins != 2'b00)
                && (coins_q == 2'b00);

  always_comb begin
    coin_val = '0;
    case (bus.coins)
      2'b01:   coin_val = CW'(5);
      2'b10:   coin_val = CW'(10);
      2'b11:   coin_val = CW'(25);
      default: coin_val = '0;
    endcase
  end

  assign sum = {1'b0, credit_q}
             + {1'b0, coin_val};

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    refund_d = refund_q;
    timer_d  = timer_q;
    ok_d     = 1'b0;
    nak_d    = 1'b0;
    rv_d     = 1'b0;
    rej_d    = 1'b0;
    to_d     = 1'b0;
    case (state_q)
      IDLE: begin
        rej_d = coin_ev;
        if (bus.arm) begin
          state_d  = COLLECT;
          credit_d = '0;
          timer_d  = T_RELOAD;
        end
      end
      COLLECT: begin
        if (bus.cancel) begin
          rej_d   = coin_ev;
          state_d = REFUND;
        end else if (bus.charge_valid) begin
          rej_d = coin_ev;
          if (bus.charge_amt <= credit_q) begin
            ok_d     = 1'b1;
            credit_d = credit_q - bus.charge_amt;
            state_d  = REFUND;
          end else begin
            nak_d   = 1'b1;
            timer_d = T_RELOAD;
          end
        end else if (coin_ev) begin
          timer_d = T_RELOAD;
          if (sum <= MAX_C) begin
            credit_d = sum[CW-1:0];
          end else begin
            rej_d = 1'b1;
          end
        end else if (timer_q == '0) begin
          to_d    = 1'b1;
          state_d = REFUND;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      REFUND: begin
        rv_d     = 1'b1;
        refund_d = credit_q;
        credit_d = '0;
        rej_d    = coin_ev;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge hrst) begin
    if (hrst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      refund_q <= '0;
      timer_q  <= '0;
      coins_q  <= 2'b00;
      ok_q     <= 1'b0;
      nak_q    <= 1'b0;
      rv_q     <= 1'b0;
      rej_q    <= 1'b0;
      to_q     <= 1'b0;
    end else if (srst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      refund_q <= '0;
      timer_q  <= '0;
      coins_q  <= 2'b00;
      ok_q     <= 1'b0;
      nak_q    <= 1'b0;
      rv_q     <= 1'b0;
      rej_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      refund_q <= refund_d;
      timer_q  <= timer_d;
      coins_q  <= bus.coins;
      ok_q     <= ok_d;
      nak_q    <= nak_d;
      rv_q     <= rv_d;
      rej_q    <= rej_d;
      to_q     <= to_d;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.charge_ok    = ok_q;
  assign bus.charge_nak   = nak_q;
  assign bus.refund_valid = rv_q;
  assign bus.refund       = refund_q;
  assign bus.reject       = rej_q;
  assign bus.timeout      = to_q;
endmodule

// File: tb/tb_vm2002_coin_acceptor.sv
// Bench for vm2002_coin_acceptor: vector table plus
// hand sequences for timeout, saturation and reset.
module tb_vm2002_coin_acceptor;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic hrst;
  logic srst;

  vm2002_coin_acceptor_if #(.CW(CW)) bus ();

  vm2002_coin_acceptor #(
    .CW(CW),
    .MAX_CREDIT(995),
    .TIMEOUT_CYC(512)
  ) dut (
    .clk(clk),
    .hrst(hrst),
    .srst(srst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    coins;
    logic          arm;
    logic          cancel;
    logic          cv;
    logic [CW-1:0] amt;
  } in_t;

  typedef struct packed {
    logic [CW-1:0] credit;
    logic          busy;
    logic          ok;
    logic          nak;
    logic          rv;
    logic [CW-1:0] refund;
    logic          rej;
    logic          to;
  } out_t;

  typedef struct {
    in_t  in;
    out_t exp;
  } vec_t;

  vec_t tbl[$];
  out_t sb[$];
  int errors = 0;
  int checks = 0;

  function automatic vec_t mk(
    input logic [1:0] c, input logic a, ca, cv,
    input int amt, input int cr,
    input logic b, ok, nak, rv,
    input int rf, input logic rj, to);
    vec_t v;
    v.in.coins   = c;
    v.in.arm     = a;
    v.in.cancel  = ca;
    v.in.cv      = cv;
    v.in.amt     = CW'(amt);
    v.exp.credit = CW'(cr);
    v.exp.busy   = b;
    v.exp.ok     = ok;
    v.exp.nak    = nak;
    v.exp.rv     = rv;
    v.exp.refund = CW'(rf);
    v.exp.rej    = rj;
    v.exp.to     = to;
    return v;
  endfunction

  function automatic out_t sample();
    out_t o;
    o.credit = bus.credit;
    o.busy   = bus.busy;
    o.ok     = bus.charge_ok;
    o.nak    = bus.charge_nak;
    o.rv     = bus.refund_valid;
    o.refund = bus.refund;
    o.rej    = bus.reject;
    o.to     = bus.timeout;
    return o;
  endfunction

  task automatic cmp(input string name, input out_t act, input out_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got cr=%0d bz=%b ok=%b nak=%b rv=%b rf=%0d rj=%b to=%b want cr=%0d bz=%b ok=%b nak=%b rv=%b rf=%0d rj=%b to=%b",
        name, act.credit, act.busy, act.ok, act.nak, act.rv, act.refund, act.rej, act.to,
        exp.credit, exp.busy, exp.ok, exp.nak, exp.rv, exp.refund, exp.rej, exp.to);
    end
  endtask

  task automatic step(input string name, input vec_t v);
    bus.coins        = v.in.coins;
    bus.arm          = v.in.arm;
    bus.cancel       = v.in.cancel;
    bus.charge_valid = v.in.cv;
    bus.charge_amt   = v.in.amt;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      cmp(name, sample(), sb.pop_front());
    end
  endtask

  initial begin
    hrst = 1'b1;
    srst = 1'b0;
    bus.coins = 2'b00;
    bus.arm = 1'b0;
    bus.cancel = 1'b0;
    bus.charge_valid = 1'b0;
    bus.charge_amt = '0;

    //            c a ca cv amt  cr b ok nk rv rf rj to
    tbl.push_back(mk(0,1,0,0, 0,   0,1,0,0,0, 0,0,0)); // arm
    tbl.push_back(mk(3,0,0,0, 0,  25,1,0,0,0, 0,0,0));
    tbl.push_back(mk(3,0,0,0, 0,  25,1,0,0,0, 0,0,0));
    tbl.push_back(mk(3,0,0,0, 0,  25,1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,  25,1,0,0,0, 0,0,0));
    tbl.push_back(mk(3,0,0,0, 0,  50,1,0,0,0, 0,0,0));
    tbl.push_back(mk(3,0,0,0, 0,  50,1,0,0,0, 0,0,0));
    tbl.push_back(mk(2,0,0,0, 0,  50,1,0,0,0, 0,0,0)); // Q->D direct
    tbl.push_back(mk(0,0,0,0, 0,  50,1,0,0,0, 0,0,0));
    tbl.push_back(mk(2,0,0,0, 0,  60,1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,0, 0,  60,1,0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,  65,1,0,0,0, 0,0,0));
    tbl.push_back(mk(1,0,0,0, 0,  65,1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,0,1,50,  15,1,1,0,0, 0,0,0)); // charge ok
    tbl.push_back(mk(0,0,0,0, 0,   0,0,0,0,1,15,0,0)); // change
    tbl.push_back(mk(0,0,1,0, 0,   0,0,0,0,0,15,0,0)); // idle cancel
    tbl.push_back(mk(0,0,0,1, 0,   0,0,0,0,0,15,0,0)); // idle charge
    tbl.push_back(mk(0,1,0,0, 0,   0,1,0,0,0,15,0,0));
    tbl.push_back(mk(2,0,0,0, 0,  10,1,0,0,0,15,0,0));
    tbl.push_back(mk(0,0,0,0, 0,  10,1,0,0,0,15,0,0));
    tbl.push_back(mk(2,0,0,0, 0,  20,1,0,0,0,15,0,0));
    tbl.push_back(mk(0,0,0,0, 0,  20,1,0,0,0,15,0,0));
    tbl.push_back(mk(1,0,0,1,50,  20,1,0,1,0,15,1,0)); // nak + reject
    tbl.push_back(mk(0,0,0,0, 0,  20,1,0,0,0,15,0,0));
    tbl.push_back(mk(3,0,0,0, 0,  45,1,0,0,0,15,0,0));
    tbl.push_back(mk(0,0,0,1,45,   0,1,1,0,0,15,0,0)); // exact charge
    tbl.push_back(mk(0,0,0,0, 0,   0,0,0,0,1, 0,0,0)); // zero refund
    tbl.push_back(mk(0,1,0,0, 0,   0,1,0,0,0, 0,0,0));
    tbl.push_back(mk(2,0,0,0, 0,  10,1,0,0,0, 0,0,0));
    tbl.push_back(mk(0,0,1,0, 0,  10,1,0,0,0, 0,0,0)); // cancel
    tbl.push_back(mk(1,0,0,0, 0,   0,0,0,0,1,10,1,0)); // coin in REFUND
    tbl.push_back(mk(0,0,0,0, 0,   0,0,0,0,0,10,0,0));
    tbl.push_back(mk(1,0,0,0, 0,   0,0,0,0,0,10,1,0)); // coin in IDLE
    tbl.push_back(mk(0,0,0,0, 0,   0,0,0,0,0,10,0,0));

    repeat (2) @(posedge clk);
    #1;
    cmp("reset", sample(), out_t'(0));
    hrst = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i]);

    // watchdog: timeout on the 512th cycle after the last coin
    step("t4_arm", mk(0,1,0,0,0, 0,1,0,0,0,10,0,0));
    step("t4_n",   mk(1,0,0,0,0, 5,1,0,0,0,10,0,0));
    for (int i = 1; i <= 512; i++)
      step($sformatf("t4_idle%0d", i),
           mk(0,0,0,0,0, 5,1,0,0,0,10,0,(i == 512)));
    step("t4_refund", mk(0,0,0,0,0, 0,0,0,0,1,5,0,0));

    // credit ceiling
    step("t5_arm", mk(0,1,0,0,0, 0,1,0,0,0,5,0,0));
    for (int i = 1; i <= 39; i++) begin
      step("t5_q",  mk(3,0,0,0,0, 25*i,1,0,0,0,5,0,0));
      step("t5_q0", mk(0,0,0,0,0, 25*i,1,0,0,0,5,0,0));
    end
    step("t5_n980", mk(1,0,0,0,0, 980,1,0,0,0,5,0,0));
    step("t5_0a",   mk(0,0,0,0,0, 980,1,0,0,0,5,0,0));
    step("t5_qrej", mk(3,0,0,0,0, 980,1,0,0,0,5,1,0));
    step("t5_0b",   mk(0,0,0,0,0, 980,1,0,0,0,5,0,0));
    step("t5_d990", mk(2,0,0,0,0, 990,1,0,0,0,5,0,0));
    step("t5_0c",   mk(0,0,0,0,0, 990,1,0,0,0,5,0,0));
    step("t5_n995", mk(1,0,0,0,0, 995,1,0,0,0,5,0,0));
    step("t5_0d",   mk(0,0,0,0,0, 995,1,0,0,0,5,0,0));
    step("t5_nrej", mk(1,0,0,0,0, 995,1,0,0,0,5,1,0));
    step("t5_cncl", mk(0,0,1,0,0, 995,1,0,0,0,5,0,0));
    step("t5_rf",   mk(0,0,0,0,0, 0,0,0,0,1,995,0,0));

    // asynchronous hard reset mid-session
    step("t6_arm", mk(0,1,0,0,0, 0,1,0,0,0,995,0,0));
    for (int i = 1; i <= 4; i++) begin
      step("t6_d",  mk(2,0,0,0,0, 10*i,1,0,0,0,995,0,0));
      step("t6_d0", mk(0,0,0,0,0, 10*i,1,0,0,0,995,0,0));
    end
    #2;
    hrst = 1'b1;
    #1;
    cmp("t6_async", sample(), out_t'(0));
    @(posedge clk);
    #1;
    hrst = 1'b0;
    step("t6_idle_coin", mk(1,0,0,0,0, 0,0,0,0,0,0,1,0));
    step("t6_idle0",     mk(0,0,0,0,0, 0,0,0,0,0,0,0,0));

    // synchronous soft reset
    step("sr_arm", mk(0,1,0,0,0, 0,1,0,0,0,0,0,0));
    step("sr_n",   mk(1,0,0,0,0, 5,1,0,0,0,0,0,0));
    srst = 1'b1;
    step("sr_rst", mk(0,0,0,0,0, 0,0,0,0,0,0,0,0));
    srst = 1'b0;
    step("sr_idle", mk(0,0,0,0,0, 0,0,0,0,0,0,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
